// File: rtl/aup_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// aup_axil_reg_slave
//
// AXI4-Lite slave register bank. Holds NUM_REGS software-visible registers
// with byte-strobe writes and single-beat reads. The register contents are
// exported on REG_Q for user logic.
//
// The AW and W channels each have an independent one-entry hold, so address
// and data may arrive in either order or together. The register write and
// BVALID happen on the edge after both holds are full. Reads are
// single-outstanding with RDATA registered at the AR handshake.
//
// Optional feature macro: AUP_AXIL_SLVERR_EN
//   defined   : addresses >= NUM_REGS*4 drop writes, read back 0, and respond
//               SLVERR (2'b10)
//   undefined : every address aliases onto its index, and responses are
//               always OKAY
//
// Parameters
//   DATA_WIDTH  AXI data width (only 32 is supported)
//   ADDR_WIDTH  AXI byte-address width
//   NUM_REGS    register count, a power of two from 2 to 16
//
// Ports
//   ACLK, ARESET            clock and synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*    write address and write data channels
//   S_AXI_B*                write response channel
//   S_AXI_AR* / S_AXI_R*    read address and read data channels
//   REG_Q                   register k at [k*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module aup_axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  // Register array and its flat export
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Write-side holds
  logic              aw_held;
  logic [IDX_W-1:0]  aw_idx;
  logic              aw_err;
  logic              w_held;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              bvalid;
  axi_resp_e         bresp;

  // Read-side state
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  axi_resp_e             rresp;

  // Held low for the first cycle after reset, so that no READY is seen while
  // reset is asserted and no combinational path runs from ARESET to an output.
  logic ready_en;

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_err_in, ar_err_in;
  logic [IDX_W-1:0] aw_idx_in, ar_idx_in;

  // Bits [1:0] are byte lanes within a word; only the word index selects.
  assign aw_idx_in = S_AXI_AWADDR[IDX_W+1:2];
  assign ar_idx_in = S_AXI_ARADDR[IDX_W+1:2];

`ifdef AUP_AXIL_SLVERR_EN
  // Widened by one bit so the compare works even when NUM_REGS*4 equals
  // 2**ADDR_WIDTH (an empty out-of-range window).
  localparam logic [ADDR_WIDTH:0] REG_SPAN = (ADDR_WIDTH+1)'(NUM_REGS*4);
  assign aw_err_in = ({1'b0, S_AXI_AWADDR} >= REG_SPAN);
  assign ar_err_in = ({1'b0, S_AXI_ARADDR} >= REG_SPAN);
`else
  assign aw_err_in = 1'b0;
  assign ar_err_in = 1'b0;
`endif

  // PROT is ignored. Address bits outside the index are only used by the
  // optional range check.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = ready_en & ~aw_held & ~bvalid;
  assign S_AXI_WREADY  = ready_en & ~w_held & ~bvalid;
  assign S_AXI_ARREADY = ready_en & ~rvalid;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  // Both holds full. BVALID is necessarily low here, because nothing is
  // accepted while it is high.
  assign commit = aw_held & w_held;

  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = bresp;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RDATA  = rdata;
  assign S_AXI_RRESP  = rresp;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_q
    assign REG_Q[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

  // NOTE: all state is updated with non-blocking assignments, so every
  // always_ff block sees pre-edge values. This is what makes a same-cycle
  // read return the pre-write register contents.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      aw_idx   <= '0;
      aw_err   <= 1'b0;
      w_held   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= aw_idx_in;
        aw_err  <= aw_err_in;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // NOTE: the register array is reset explicitly. These are software-visible
  // control registers that must read as zero after reset, so the array is
  // built from resettable flops rather than inferred as RAM.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else if (commit && !aw_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) begin
          regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= ar_err_in ? '0 : regs[ar_idx_in];
      rresp  <= ar_err_in ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aup_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_aup_axil_reg_slave
//
// Self-checking bench for aup_axil_reg_slave (default parameters). A table of
// write/read vectors is applied in a loop. Expected B and R responses are
// queued when a transaction is driven, then popped and compared when the DUT
// presents them. Hand-written sequences cover the following cases:
//   - out-of-order W/AW arrival with B back-pressure
//   - a read and a write to the same register in the same cycle
//   - reset while a read response is pending
//   - an access beyond the register window
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_aup_axil_reg_slave;

  localparam int TMO = 50;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         aclk = 1'b0;
  logic         areset;
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0]  rdata;
  logic [127:0] reg_q;

  always #5 aclk = ~aclk;

  aup_axil_reg_slave dut (
    .ACLK          (aclk),
    .ARESET        (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .REG_Q         (reg_q)
  );

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  b_q [$];
  rexp_t       r_q [$];
  logic [31:0] mdl [4];
  vec_t        vecs [14];

  function automatic logic [127:0] mdl_q();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no DUT event within %0d cycles", name, TMO);
  endtask

  // Expected contents after a write that the DUT should accept
  task automatic model_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) mdl[addr[3:2]][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic drive_aw_w(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0;
    w_done  = 1'b0;
    @(negedge aclk);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    for (int n = 0; n < TMO && !(aw_done && w_done); n++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge aclk);
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) bound_fail("aw_w_handshake");
  endtask

  task automatic drive_ar(input logic [5:0] addr);
    bit done, hs;
    done = 1'b0;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1;
    for (int n = 0; n < TMO && !done; n++) begin
      hs = arvalid && arready;
      @(negedge aclk);
      if (hs) done = 1'b1;
    end
    arvalid = 1'b0;
    if (!done) bound_fail("ar_handshake");
  endtask

  // Called on a falling edge. Compares the first presented B beat against
  // the queue head, then steps one cycle so that the handshake completes.
  task automatic wait_b(input string name);
    logic [1:0] e;
    for (int n = 0; n < TMO; n++) begin
      if (bvalid) begin
        if (b_q.size() == 0) bound_fail({name, "_unexpected_b"});
        else begin
          e = b_q.pop_front();
          check({name, "_bresp"}, bresp, e);
        end
        @(negedge aclk);
        return;
      end
      @(negedge aclk);
    end
    bound_fail({name, "_bvalid"});
  endtask

  task automatic wait_r(input string name);
    rexp_t e;
    for (int n = 0; n < TMO; n++) begin
      if (rvalid) begin
        if (r_q.size() == 0) bound_fail({name, "_unexpected_r"});
        else begin
          e = r_q.pop_front();
          check({name, "_rdata"}, rdata, e.data);
          check({name, "_rresp"}, rresp, e.resp);
        end
        @(negedge aclk);
        return;
      end
      @(negedge aclk);
    end
    bound_fail({name, "_rvalid"});
  endtask

  task automatic axi_write(input string name, input logic [5:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp);
    b_q.push_back(exp_resp);
    if (exp_resp == OKAY) model_write(addr, data, strb);
    drive_aw_w(addr, data, strb);
    wait_b(name);
  endtask

  task automatic axi_read(input string name, input logic [5:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    r_q.push_back('{data: exp_data, resp: exp_resp});
    drive_ar(addr);
    wait_r(name);
  endtask

  initial begin
    logic [1:0] held_resp;

    // Table: writes then readbacks (basic map, byte strobes, WSTRB=0, low
    // address bits ignored).
    vecs[0]  = '{1'b1, 6'h00, 32'h0000_0001, 4'hF, 32'h0,          OKAY};
    vecs[1]  = '{1'b1, 6'h04, 32'h0000_0002, 4'hF, 32'h0,          OKAY};
    vecs[2]  = '{1'b1, 6'h08, 32'h0000_0003, 4'hF, 32'h0,          OKAY};
    vecs[3]  = '{1'b1, 6'h0C, 32'h0000_0004, 4'hF, 32'h0,          OKAY};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,         4'h0, 32'h0000_0001,  OKAY};
    vecs[5]  = '{1'b0, 6'h04, 32'h0,         4'h0, 32'h0000_0002,  OKAY};
    vecs[6]  = '{1'b0, 6'h08, 32'h0,         4'h0, 32'h0000_0003,  OKAY};
    vecs[7]  = '{1'b0, 6'h0C, 32'h0,         4'h0, 32'h0000_0004,  OKAY};
    vecs[8]  = '{1'b1, 6'h04, 32'hAABB_CCDD, 4'hF, 32'h0,          OKAY};
    vecs[9]  = '{1'b1, 6'h04, 32'h1122_3344, 4'h5, 32'h0,          OKAY};
    vecs[10] = '{1'b0, 6'h04, 32'h0,         4'h0, 32'hAA22_CC44,  OKAY};
    vecs[11] = '{1'b1, 6'h04, 32'hFFFF_FFFF, 4'h0, 32'h0,          OKAY};
    vecs[12] = '{1'b0, 6'h04, 32'h0,         4'h0, 32'hAA22_CC44,  OKAY};
    vecs[13] = '{1'b0, 6'h07, 32'h0,         4'h0, 32'hAA22_CC44,  OKAY};

    for (int i = 0; i < 4; i++) mdl[i] = '0;
    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1;

    // Reset state, sampled while reset is still asserted
    repeat (3) @(negedge aclk);
    check("reset_ready_valid", {awready, wready, arready, bvalid, rvalid}, '0);
    check("reset_resp", {bresp, rresp}, '0);
    check("reset_rdata", rdata, '0);
    check("reset_reg_q", reg_q, '0);
    areset = 1'b0;
    @(negedge aclk);
    check("idle_ready", {awready, wready, arready}, 3'b111);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr)
        axi_write($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].data,
                  vecs[i].strb, vecs[i].exp_resp);
      else
        axi_read($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_data,
                 vecs[i].exp_resp);
    end
    check("strobe_reg_q_word1", reg_q[63:32], 32'hAA22_CC44);
    check("table_reg_q", reg_q, mdl_q());

    // W first, AW three cycles later, B held off for four cycles
    bready = 1'b0;
    b_q.push_back(OKAY);
    model_write(6'h0C, 32'h5A5A_0F0F, 4'hF);
    @(negedge aclk);
    wdata = 32'h5A5A_0F0F; wstrb = 4'hF; wvalid = 1'b1;
    check("ooo_wready", wready, 1'b1);
    @(negedge aclk);
    wvalid = 1'b0;
    check("ooo_w_held", {awready, wready, bvalid}, 3'b100);
    repeat (2) @(negedge aclk);
    awaddr = 6'h0C; awvalid = 1'b1;
    check("ooo_awready", awready, 1'b1);
    @(negedge aclk);
    awvalid = 1'b0;
    check("ooo_both_held", {awready, wready, bvalid}, 3'b000);
    @(negedge aclk);
    check("ooo_bvalid_rise", bvalid, 1'b1);
    if (b_q.size() != 0) begin
      held_resp = b_q.pop_front();
      check("ooo_bresp", bresp, held_resp);
    end else bound_fail("ooo_queue");
    check("ooo_reg_q_at_bvalid", reg_q, mdl_q());
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check($sformatf("ooo_hold%0d", c), {bvalid, awready, wready, bresp},
            {3'b100, held_resp});
    end
    bready = 1'b1;
    @(negedge aclk);
    check("ooo_b_done", {bvalid, awready, wready}, 3'b011);

    // Read and write of 0x8 accepted on the same edge
    b_q.push_back(OKAY);
    r_q.push_back('{data: 32'h3, resp: OKAY});
    model_write(6'h08, 32'h99, 4'hF);
    awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 6'h08; arvalid = 1'b1;
    check("same_cycle_ready", {awready, wready, arready}, 3'b111);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_r("same_cycle_rd");
    wait_b("same_cycle_wr");
    axi_read("same_cycle_followup", 6'h08, 32'h99, OKAY);

    // Reset while a read response is pending
    rready = 1'b0;
    axi_read("rst_pending_rd", 6'h00, 32'h1, OKAY);
    check("rst_pending_rvalid_held", rvalid, 1'b1);
    areset = 1'b1;
    @(negedge aclk);
    check("rst_pending_rvalid_clear", {rvalid, bvalid}, 2'b00);
    check("rst_pending_reg_q", reg_q, '0);
    areset = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    repeat (3) @(negedge aclk);
    check("rst_no_late_r", rvalid, 1'b0);
    axi_read("rst_reg0", 6'h00, 32'h0, OKAY);

    // Access just beyond the register window
`ifdef AUP_AXIL_SLVERR_EN
    axi_write("oob_wr", 6'h10, 32'hDEAD_BEEF, 4'hF, SLVERR);
    axi_read("oob_rd", 6'h10, 32'h0, SLVERR);
    axi_read("oob_reg0", 6'h00, 32'h0, OKAY);
`else
    axi_write("oob_wr", 6'h10, 32'hDEAD_BEEF, 4'hF, OKAY);
    axi_read("oob_rd", 6'h10, 32'hDEAD_BEEF, OKAY);
    axi_read("oob_reg0", 6'h00, 32'hDEAD_BEEF, OKAY);
`endif
    check("final_reg_q", reg_q, mdl_q());
    check("scoreboard_empty", {b_q.size() == 0, r_q.size() == 0}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
